// File: rtl/symbol_transmitter_if.sv
// Payload symbol stream into the transmitter.
// Valid/ready handshake; the transmitter is the slave.
interface symbol_transmitter_if;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;

  modport master (
    output sym_in,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_in,
    input  sym_valid,
    output sym_ready
  );
endinterface

// File: rtl/symbol_transmitter.sv
// Framed QPSK sample source: preamble, FIFO payload, zero tail.
// Each symbol is held for SPS samples; output is {I, Q}.
module symbol_transmitter #(
  parameter int               SPS          = 4,
  parameter int               FIFO_DEPTH   = 8,
  parameter int               PREAMBLE_LEN = 8,
  parameter logic signed [15:0] AMP        = 16'sd11585
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          frame_len,
  symbol_transmitter_if.slave  sym,
  output logic [31:0]          out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    PAY,
    TAIL
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty;
  logic          push, pop;
  logic [CW-1:0] cnt;
  logic [15:0]   sym_cnt, flen;
  logic [15:0]   pay_nxt;
  logic          slot_start, slot_end;
  logic          pre_last;

  function automatic logic [31:0] map_sym(input logic [1:0] s);
    logic signed [15:0] i_v, q_v;
    i_v = s[1] ? -AMP : AMP;
    q_v = s[0] ? -AMP : AMP;
    return {i_v, q_v};
  endfunction

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign sym.sym_ready = !full;
  assign push = sym.sym_valid && !full;

  assign slot_start = cnt == '0;
  assign slot_end   = cnt == CW'(SPS - 1);
  assign pre_last   = sym_cnt == 16'(PREAMBLE_LEN - 1);

  assign pop = (state == PAY) && slot_start && !empty;

  // Count including a pop on this edge, so SPS=1 ends on time
  assign pay_nxt = sym_cnt + {15'd0, pop};

  assign busy = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = PRE;
      end
      PRE: begin
        if (slot_end && pre_last)
          state_nxt = (flen == '0) ? TAIL : PAY;
      end
      PAY: begin
        if (slot_end && pay_nxt == flen) state_nxt = TAIL;
      end
      TAIL: begin
        if (slot_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sym.sym_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      sym_cnt   <= '0;
      flen      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= state != IDLE;
      // Only the tail exit leaves IDLE with out_valid still high
      done      <= out_valid && (state == IDLE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= (state == IDLE || slot_end) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          out     <= '0;
          sym_cnt <= '0;
          if (start) begin
            flen     <= frame_len;
            underrun <= 1'b0;
          end
        end
        PRE: begin
          if (slot_start)
            out <= sym_cnt[0] ? map_sym(2'b11) : map_sym(2'b00);
          if (slot_end)
            sym_cnt <= pre_last ? '0 : sym_cnt + 16'd1;
        end
        PAY: begin
          if (slot_start) begin
            out <= empty ? '0 : map_sym(mem[rd_ptr[AW-1:0]]);
            if (empty) underrun <= 1'b1;
          end
          sym_cnt <= pay_nxt;
        end
        TAIL: begin
          if (slot_start) out <= '0;
        end
        default: out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_transmitter.sv
// Directed bench for symbol_transmitter with a queue-based frame model.
// Model and literal expectations are compared on falling edges.
module tb_symbol_transmitter;

  localparam int SPS   = 4;
  localparam int DEPTH = 8;
  localparam int PL    = 8;

  localparam logic [31:0] S00 = 32'h2D412D41;
  localparam logic [31:0] S01 = 32'h2D41D2BF;
  localparam logic [31:0] S10 = 32'hD2BF2D41;
  localparam logic [31:0] S11 = 32'hD2BFD2BF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frame_len = 16'd0;
  logic [31:0] out;
  logic        out_valid, busy, done, underrun;

  symbol_transmitter_if bus();

  symbol_transmitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .sym       (bus),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mapv(input logic [1:0] s);
    logic [15:0] i_v, q_v;
    i_v = s[1] ? 16'(-11585) : 16'(11585);
    q_v = s[0] ? 16'(-11585) : 16'(11585);
    return {i_v, q_v};
  endfunction

  // Frame model: sample index within the frame plus a symbol queue
  logic [1:0]  mq[$];
  bit          m_act = 0, m_tail = 0;
  int          m_idx = 0, m_sent = 0, m_flen = 0;
  logic [31:0] m_out = '0;
  bit          m_valid = 0, m_done = 0, m_under = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_tail = 0; m_idx = 0; m_sent = 0;
      m_out = '0; m_valid = 0; m_done = 0; m_under = 0;
    end else begin
      bit psh;
      int sub, slot;
      psh = bus.sym_valid && (mq.size() < DEPTH);
      if (!m_act) begin
        m_done = m_valid;
        m_valid = 0;
        m_out = '0;
        if (start) begin
          m_act = 1; m_idx = 0; m_sent = 0; m_tail = 0;
          m_flen = int'(frame_len); m_under = 0;
        end
      end else begin
        m_done = 0;
        sub = m_idx % SPS;
        slot = m_idx / SPS;
        if (sub == 0) begin
          if (slot < PL) m_out = (slot % 2 != 0) ? S11 : S00;
          else if (m_sent < m_flen) begin
            if (mq.size() > 0) begin
              m_out = mapv(mq.pop_front());
              m_sent++;
            end else begin
              m_out = '0;
              m_under = 1;
            end
          end else begin
            m_out = '0;
            m_tail = 1;
          end
        end
        m_valid = 1;
        if (m_tail && sub == SPS - 1) m_act = 0;
        m_idx++;
      end
      if (psh) mq.push_back(bus.sym_in);
    end
  end

  logic [31:0] cap[$];

  always @(negedge clk) begin
    chk("out", out, m_out);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("sym_ready", 32'(bus.sym_ready), 32'(mq.size() < DEPTH));
    if (out_valid) cap.push_back(out);
  end

  task automatic push_sym(input logic [1:0] s);
    bus.sym_in = s;
    bus.sym_valid = 1'b1;
    @(negedge clk);
    bus.sym_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    frame_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] pay_tab [4];
    logic [31:0] e;
    pay_tab[0] = S00; pay_tab[1] = S01;
    pay_tab[2] = S10; pay_tab[3] = S11;
    bus.sym_in = 2'b00;
    bus.sym_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out", out, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.sym_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with preloaded payload
    push_sym(2'b00); push_sym(2'b01);
    push_sym(2'b10); push_sym(2'b11);
    cap.delete();
    start_frame(16'd4);
    wait_done("t2");
    chk("t2_len", 32'(cap.size()), 32'd52);
    for (int i = 0; i < 52 && i < cap.size(); i++) begin
      if (i < 32) e = ((i / 4) % 2 != 0) ? S11 : S00;
      else if (i < 48) e = pay_tab[(i - 32) / 4];
      else e = 32'd0;
      chk($sformatf("t2_s%0d", i), cap[i], e);
    end
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_under", 32'(underrun), 32'd0);

    // Empty payload: preamble then tail only
    cap.delete();
    start_frame(16'd0);
    wait_done("t3");
    chk("t3_len", 32'(cap.size()), 32'd36);
    if (cap.size() == 36) chk("t3_tail", cap[35], 32'd0);

    // Reset in the middle of the payload
    push_sym(2'b11); push_sym(2'b10); push_sym(2'b01);
    start_frame(16'd2);
    repeat (36) @(negedge clk);
    chk("t1_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_out", out, 32'd0);
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_ready", 32'(bus.sym_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Underrun: FIFO left empty by the reset
    cap.delete();
    start_frame(16'd2);
    repeat (30) @(negedge clk);
    push_sym(2'b10);
    repeat (10) @(negedge clk);
    push_sym(2'b01);
    wait_done("t4");
    chk("t4_under", 32'(underrun), 32'd1);
    chk("t4_len", 32'(cap.size()), 32'd52);
    if (cap.size() == 52) begin
      chk("t4_d0", cap[32], S10);
      chk("t4_z0", cap[36], 32'd0);
      chk("t4_z1", cap[40], 32'd0);
      chk("t4_d1", cap[44], S01);
      chk("t4_tail", cap[48], 32'd0);
    end

    // FIFO fill to depth, ninth symbol held
    for (int i = 0; i < 9; i++) begin
      bus.sym_in = 2'(i);
      bus.sym_valid = 1'b1;
      @(negedge clk);
      if (i == 6) chk("t5_ready7", 32'(bus.sym_ready), 32'd1);
      if (i >= 7) chk("t5_full", 32'(bus.sym_ready), 32'd0);
    end
    bus.sym_valid = 1'b0;
    cap.delete();
    start_frame(16'd8);
    wait_done("t5");
    chk("t5_len", 32'(cap.size()), 32'd68);
    if (cap.size() == 68)
      for (int j = 0; j < 8; j++)
        chk($sformatf("t5_p%0d", j), cap[32 + 4 * j], pay_tab[j % 4]);

    // start and frame_len changes during a frame are ignored
    push_sym(2'b01); push_sym(2'b10);
    push_sym(2'b11); push_sym(2'b00);
    cap.delete();
    start_frame(16'd4);
    repeat (40) @(negedge clk);
    frame_len = 16'd9;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("t6");
    chk("t6_len", 32'(cap.size()), 32'd52);
    chk("t6_under", 32'(underrun), 32'd0);
    @(negedge clk);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
